config_chain_loader: RTL and testbench

- Bitstream loader that sits directly upstream of the configuration-chain flip-flops (DFFRX1 cells chained head-to-tail).
- Accepts configuration words over a valid/ready interface and serialises them MSB-first onto ccff_head.
- Asserts shift_en on exactly CHAIN_LEN cycles, which gates prog_clk into the chain.
- Accumulates a parity checksum of the old chain contents returned on ccff_tail, for readback checking.

---
 rtl/config_chain_loader.sv | 97 +++++++++
 tb/tb_config_chain_loader.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/config_chain_loader.sv
// Configuration-chain bitstream loader: serialises valid/ready words MSB-first onto ccff_head,
// gates exactly CHAIN_LEN shift cycles and folds the returning tail bits into a parity bit.
module config_chain_loader #(
    parameter int unsigned WORD_W    = 8,
    parameter int unsigned CHAIN_LEN = 20,
    parameter int unsigned CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              ccff_head,
    output logic              shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              tail_parity
);

    localparam int unsigned NB_W = $clog2(WORD_W + 1);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StLoad  = 2'd1;
    localparam logic [1:0] StShift = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    localparam logic [CNT_W-1:0] ChainLen = CNT_W'(CHAIN_LEN);
    localparam logic [NB_W-1:0]  WordW    = NB_W'(WORD_W);

    logic [1:0]        state_q, state_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [NB_W-1:0]   nbits_q, nbits_d;
    logic [CNT_W-1:0]  remaining_q, remaining_d;
    logic              parity_q, parity_d;

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        nbits_d     = nbits_q;
        remaining_d = remaining_q;
        parity_d    = parity_q;
        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d     = StLoad;
                    remaining_d = ChainLen;
                    parity_d    = 1'b0;
                end
            end
            StLoad: begin
                if (cfg_valid) begin
                    shreg_d = cfg_data;
                    // A short final word only contributes its upper bits.
                    nbits_d = (32'(remaining_q) < WORD_W) ? NB_W'(remaining_q) : WordW;
                    state_d = StShift;
                end
            end
            StShift: begin
                shreg_d     = shreg_q << 1;
                nbits_d     = nbits_q - NB_W'(1);
                remaining_d = remaining_q - CNT_W'(1);
                parity_d    = parity_q ^ ccff_tail;
                if (nbits_q == NB_W'(1)) begin
                    state_d = (remaining_q == CNT_W'(1)) ? StDone : StLoad;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            state_q     <= StIdle;
            shreg_q     <= '0;
            nbits_q     <= '0;
            remaining_q <= '0;
            parity_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            nbits_q     <= nbits_d;
            remaining_q <= remaining_d;
            parity_q    <= parity_d;
        end
    end

    // Chain-facing outputs come from registered state only, never from cfg_* inputs.
    assign cfg_ready   = (state_q == StLoad);
    assign shift_en    = (state_q == StShift);
    assign ccff_head   = shift_en & shreg_q[WORD_W-1];
    assign busy        = (state_q == StLoad) || (state_q == StShift);
    assign done        = (state_q == StDone);
    assign tail_parity = parity_q;

endmodule

// File: tb/tb_config_chain_loader.sv
// Directed bench for config_chain_loader: a 20-bit and a 16-bit chain driven from the same
// word stream, checked every cycle against a stream/parity model plus literal expectations.
module tb_config_chain_loader;

    localparam int unsigned W  = 8;
    localparam int unsigned LA = 20;
    localparam int unsigned LB = 16;

    logic prog_clk = 1'b0;
    always #5 prog_clk = ~prog_clk;

    logic pReset;

    logic         a_start, a_valid;
    logic [W-1:0] a_data;
    logic         a_ready, a_head, a_sen, a_busy, a_done, a_par, a_tail;
    logic         b_start, b_valid;
    logic [W-1:0] b_data;
    logic         b_ready, b_head, b_sen, b_busy, b_done, b_par, b_tail;

    config_chain_loader #(.WORD_W(W), .CHAIN_LEN(LA)) dut_a (
        .prog_clk(prog_clk), .pReset(pReset), .start(a_start), .cfg_data(a_data),
        .cfg_valid(a_valid), .cfg_ready(a_ready), .ccff_head(a_head), .shift_en(a_sen),
        .ccff_tail(a_tail), .busy(a_busy), .done(a_done), .tail_parity(a_par)
    );

    config_chain_loader #(.WORD_W(W), .CHAIN_LEN(LB)) dut_b (
        .prog_clk(prog_clk), .pReset(pReset), .start(b_start), .cfg_data(b_data),
        .cfg_valid(b_valid), .cfg_ready(b_ready), .ccff_head(b_head), .shift_en(b_sen),
        .ccff_tail(b_tail), .busy(b_busy), .done(b_done), .tail_parity(b_par)
    );

    // Chain flip-flops: capture head while shift_en, with a bench-side preload port.
    logic [LA-1:0] a_chain, a_pre_val;
    logic [LB-1:0] b_chain, b_pre_val;
    logic          a_pre_en, b_pre_en;
    always @(posedge prog_clk) begin
        if (a_pre_en) a_chain <= a_pre_val;
        else if (a_sen) a_chain <= {a_chain[LA-2:0], a_head};
        if (b_pre_en) b_chain <= b_pre_val;
        else if (b_sen) b_chain <= {b_chain[LB-2:0], b_head};
    end
    assign a_tail = a_chain[LA-1];
    assign b_tail = b_chain[LB-1];

    int unsigned checks = 0;
    int unsigned errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Model: the chain image is the first L bits of the word stream, first bit at the MSB.
    logic [LA-1:0] a_exp;
    logic [LB-1:0] b_exp;

    int unsigned   a_sh, a_hs, a_cyc, b_sh, b_hs, b_cyc;
    logic [LA-1:0] a_seen;
    logic [LB-1:0] b_seen;
    logic          a_snap, b_snap;
    logic          a_busy_prev = 1'b0, a_done_prev = 1'b0;
    logic          b_busy_prev = 1'b0, b_done_prev = 1'b0;

    always @(negedge prog_clk) begin
        if (pReset) begin
            check("reset_outputs_a", 32'({a_ready, a_head, a_sen, a_busy, a_done, a_par}), 0);
            check("reset_outputs_b", 32'({b_ready, b_head, b_sen, b_busy, b_done, b_par}), 0);
            a_busy_prev = 1'b0; a_done_prev = 1'b0;
            b_busy_prev = 1'b0; b_done_prev = 1'b0;
        end else begin
            if (a_busy && !a_busy_prev) begin
                a_sh = 0; a_hs = 0; a_cyc = 0; a_seen = '0; a_snap = ^a_chain;
            end
            if (a_busy) a_cyc++;
            if (a_ready && a_valid) a_hs++;
            if (a_sen) begin
                if (a_sh < LA) check("a_head_bit", 32'(a_head), 32'(a_exp[LA-1-a_sh]));
                else check("a_shift_overrun", a_sh + 1, LA);
                a_seen = {a_seen[LA-2:0], a_head};
                a_sh++;
            end else begin
                check("a_head_idle", 32'(a_head), 0);
            end
            if (a_done) begin
                check("a_done_quiet", 32'({a_ready, a_busy, a_sen}), 0);
                check("a_parity", 32'(a_par), 32'(a_snap));
                if (!a_done_prev) begin
                    check("a_shift_total", a_sh, LA);
                    check("a_chain_image", 32'(a_chain), 32'(a_exp));
                end
            end else if (!a_busy) begin
                check("a_parity_idle", 32'(a_par), 0);
            end
            a_busy_prev = a_busy; a_done_prev = a_done;

            if (b_busy && !b_busy_prev) begin
                b_sh = 0; b_hs = 0; b_cyc = 0; b_seen = '0; b_snap = ^b_chain;
            end
            if (b_busy) b_cyc++;
            if (b_ready && b_valid) b_hs++;
            if (b_sen) begin
                if (b_sh < LB) check("b_head_bit", 32'(b_head), 32'(b_exp[LB-1-b_sh]));
                else check("b_shift_overrun", b_sh + 1, LB);
                b_seen = {b_seen[LB-2:0], b_head};
                b_sh++;
            end else begin
                check("b_head_idle", 32'(b_head), 0);
            end
            if (b_done) begin
                check("b_done_quiet", 32'({b_ready, b_busy, b_sen}), 0);
                check("b_parity", 32'(b_par), 32'(b_snap));
                if (!b_done_prev) begin
                    check("b_shift_total", b_sh, LB);
                    check("b_chain_image", 32'(b_chain), 32'(b_exp));
                end
            end
            b_busy_prev = b_busy; b_done_prev = b_done;
        end
    end

    // Waits for cfg_ready (cfg_valid already high) and returns just after the accepting edge.
    task automatic hs_a();
        int unsigned n = 0;
        do begin @(negedge prog_clk); n++; end while (!a_ready && n < 50);
        check("a_accept_wait", 32'(a_ready), 1);
        @(posedge prog_clk); #1;
    endtask

    task automatic hs_b();
        int unsigned n = 0;
        do begin @(negedge prog_clk); n++; end while (!b_ready && n < 50);
        check("b_accept_wait", 32'(b_ready), 1);
        @(posedge prog_clk); #1;
    endtask

    task automatic load_a(input logic [LA-1:0] pre, input int unsigned stall,
                          input logic poke_start, input logic abort, input logic exp_par);
        int unsigned n = 0;
        a_pre_val = pre; a_pre_en = 1'b1;
        @(posedge prog_clk); #1;
        a_pre_en = 1'b0;
        a_start = 1'b1; a_data = 8'hA5; a_valid = 1'b1;
        @(posedge prog_clk); #1;
        a_start = 1'b0;
        check("a_start_response", 32'({a_busy, a_done}), 32'h2);
        hs_a();
        if (abort) begin
            repeat (3) @(posedge prog_clk);
            #2 pReset = 1'b1;
            #1 check("abort_async", 32'({a_ready, a_head, a_sen, a_busy, a_done, a_par}), 0);
            @(posedge prog_clk); #1;
            pReset = 1'b0; a_valid = 1'b0;
            @(posedge prog_clk); #1;
            check("abort_idle", 32'({a_busy, a_done, a_ready, a_sen}), 0);
        end else begin
            a_data = 8'h3C;
            if (poke_start) begin
                a_start = 1'b1;
                @(posedge prog_clk); #1;
                a_start = 1'b0;
            end
            if (stall != 0) begin
                a_valid = 1'b0;
                do begin @(negedge prog_clk); n++; end while (!a_ready && n < 50);
                repeat (stall - 1) @(negedge prog_clk);
                @(posedge prog_clk); #1;
                a_valid = 1'b1;
            end
            hs_a();
            a_data = 8'hF0;
            hs_a();
            a_data = 8'h5A;  // offered after the last word; must never be taken
            n = 0;
            do begin @(negedge prog_clk); n++; end while (!a_done && n < 60);
            #1;
            check("a_done_wait", 32'(a_done), 1);
            check("a_shift_cycles", a_sh, 20);
            check("a_handshakes", a_hs, 3);
            check("a_latency", a_cyc, 23 + stall);
            check("a_serial_stream", 32'(a_seen), 32'hA53CF);
            check("a_parity_literal", 32'(a_par), 32'(exp_par));
        end
    endtask

    initial begin
        logic [3*W-1:0] cat;
        int unsigned n;
        cat   = {8'hA5, 8'h3C, 8'hF0};
        a_exp = cat[3*W-1 -: LA];
        b_exp = cat[3*W-1 -: LB];

        pReset = 1'b0;
        a_start = 1'b0; a_valid = 1'b0; a_data = '0; a_pre_en = 1'b0; a_pre_val = '0;
        b_start = 1'b0; b_valid = 1'b0; b_data = '0; b_pre_en = 1'b0; b_pre_val = '0;
        #1 pReset = 1'b1;
        #2 check("reset_async", 32'({a_ready, a_head, a_sen, a_busy, a_done, a_par}), 0);
        repeat (2) @(posedge prog_clk);
        #1 pReset = 1'b0;
        a_pre_en = 1'b1; b_pre_en = 1'b1;
        @(posedge prog_clk); #1;
        a_pre_en = 1'b0; b_pre_en = 1'b0;

        // Exact fit on the 16-bit chain: two whole words, no discard.
        b_start = 1'b1; b_data = 8'hA5; b_valid = 1'b1;
        @(posedge prog_clk); #1;
        b_start = 1'b0;
        hs_b();
        b_data = 8'h3C;
        hs_b();
        b_data = 8'hF0;
        n = 0;
        do begin @(negedge prog_clk); n++; end while (!b_done && n < 60);
        #1;
        check("b_done_wait", 32'(b_done), 1);
        check("b_shift_cycles", b_sh, 16);
        check("b_handshakes", b_hs, 2);
        check("b_latency", b_cyc, 18);
        check("b_serial_stream", 32'(b_seen), 32'hA53C);
        check("b_parity_literal", 32'(b_par), 0);
        b_valid = 1'b0;

        load_a(20'hAAA80, 0, 1'b0, 1'b0, 1'b1);  // seven ones preloaded
        load_a(20'h00000, 5, 1'b1, 1'b0, 1'b0);  // restart from DONE, stall, start mid-shift
        load_a(20'hFFFFF, 0, 1'b0, 1'b1, 1'b0);  // reset mid-shift
        load_a(20'h00001, 0, 1'b0, 1'b0, 1'b1);  // normal load after abort

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
